// File: rtl/bht_predictor_if.sv
// Fetch/ALU/ROB-facing signal bundle of the branch predictor.
// Handshake: predictor_enable_if is a one-cycle valid pulse for predict_jump_pc with no ready;
// IF must hold while predictor_stall_if=1, and rob_update_en/jump_wrong/alu_broadcast are single-cycle strobes.
`ifndef OPLEN
`define OPLEN 6
`endif
`ifndef JALR
`define JALR 6'd9
`endif

interface bht_predictor_if #(
  parameter int PERF_W = 16
);
  logic              if_success;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              is_jump_instr;
  logic              predicted_jump;
  logic [31:0]       predict_jump_pc;
  logic              predictor_enable_if;
  logic              predictor_stall_if;
  logic              alu_broadcast;
  logic [`OPLEN-1:0] alu_broadcast_op;
  logic [31:0]       alu_jumping_pc;
  logic              rob_update_en;
  logic [31:0]       rob_update_pc;
  logic              rob_real_jump;
  logic              jump_wrong;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispredicts;

  modport master (
    output if_success, if_pc, if_instr,
    output alu_broadcast, alu_broadcast_op, alu_jumping_pc,
    output rob_update_en, rob_update_pc, rob_real_jump, jump_wrong,
    input  is_jump_instr, predicted_jump, predict_jump_pc,
    input  predictor_enable_if, predictor_stall_if,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_success, if_pc, if_instr,
    input  alu_broadcast, alu_broadcast_op, alu_jumping_pc,
    input  rob_update_en, rob_update_pc, rob_real_jump, jump_wrong,
    output is_jump_instr, predicted_jump, predict_jump_pc,
    output predictor_enable_if, predictor_stall_if,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bht_predictor.sv
// Fetch-stage next-PC predictor: saturating-counter BHT for branches, JAL always taken,
// JALR stalls IF until the ALU resolves its target; ROB commits train the table.
module bht_predictor #(
  parameter int IDX_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int CTR_INIT = 1,
  parameter int PERF_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  bht_predictor_if.slave bus,
  output logic           state_dbg
);

  localparam int                  ENTRIES   = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(CTR_INIT);
  localparam logic [6:0]          OP_JAL    = 7'd111;
  localparam logic [6:0]          OP_JALR   = 7'd103;
  localparam logic [6:0]          OP_BRANCH = 7'd99;

  typedef enum logic {
    IDLE,
    WAIT_JALR
  } state_t;

  state_t              state_q, state_d;
  logic                jump_q, jump_d;
  logic                taken_q, taken_d;
  logic                en_q, en_d;
  logic                stall_q, stall_d;
  logic [31:0]         pc_q, pc_d;
  logic [PERF_W-1:0]   br_q, br_d;
  logic [PERF_W-1:0]   mis_q, mis_d;
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [6:0]          opcode;
  logic [31:0]         j_imm, b_imm, seq_pc;
  logic [IDX_BITS-1:0] lookup_idx, train_idx;
  logic [CTR_BITS-1:0] lookup_ctr, train_ctr, train_ctr_next;
  logic                alu_jalr;
  logic                unused_pc_bits;

  // Instruction field extraction
  assign opcode = bus.if_instr[6:0];
  assign j_imm  = {{12{bus.if_instr[31]}}, bus.if_instr[19:12], bus.if_instr[20],
                   bus.if_instr[30:21], 1'b0};
  assign b_imm  = {{20{bus.if_instr[31]}}, bus.if_instr[7], bus.if_instr[30:25],
                   bus.if_instr[11:8], 1'b0};
  assign seq_pc = bus.if_pc + 32'd4;

  assign lookup_idx     = bus.if_pc[IDX_BITS+1:2];
  assign lookup_ctr     = ctr_q[lookup_idx];
  assign train_idx      = bus.rob_update_pc[IDX_BITS+1:2];
  assign train_ctr      = ctr_q[train_idx];
  assign alu_jalr       = bus.alu_broadcast && (bus.alu_broadcast_op == `JALR);
  assign unused_pc_bits = ^{bus.rob_update_pc[31:IDX_BITS+2], bus.rob_update_pc[1:0]};

  // Saturating step of the trained entry; reads the pre-update value so a
  // same-cycle lookup of the same index still sees the old prediction.
  always_comb begin
    train_ctr_next = train_ctr;
    if (bus.rob_real_jump) begin
      if (train_ctr != CTR_MAX) train_ctr_next = train_ctr + 1'b1;
    end else begin
      if (train_ctr != '0) train_ctr_next = train_ctr - 1'b1;
    end
  end

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (bus.rob_update_en && (br_q != '1)) br_d = br_q + 1'b1;
    if (bus.jump_wrong && (mis_q != '1)) mis_d = mis_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    jump_d  = jump_q;
    taken_d = taken_q;
    pc_d    = pc_q;
    stall_d = stall_q;
    en_d    = 1'b0;
    if (bus.jump_wrong) begin
      // Flush wins over this cycle's lookup and JALR resolution.
      stall_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_success) begin
            case (opcode)
              OP_JAL: begin
                jump_d  = 1'b1;
                taken_d = 1'b1;
                pc_d    = bus.if_pc + j_imm;
                en_d    = 1'b1;
              end
              OP_JALR: begin
                jump_d  = 1'b1;
                taken_d = 1'b1;
                stall_d = 1'b1;
                state_d = WAIT_JALR;
              end
              OP_BRANCH: begin
                jump_d  = 1'b1;
                taken_d = lookup_ctr[CTR_BITS-1];
                pc_d    = lookup_ctr[CTR_BITS-1] ? (bus.if_pc + b_imm) : seq_pc;
                en_d    = 1'b1;
              end
              default: begin
                jump_d  = 1'b0;
                taken_d = 1'b0;
                pc_d    = seq_pc;
                en_d    = 1'b1;
              end
            endcase
          end
        end
        WAIT_JALR: begin
          if (alu_jalr) begin
            jump_d  = 1'b1;
            taken_d = 1'b1;
            pc_d    = bus.alu_jumping_pc;
            stall_d = 1'b0;
            en_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      jump_q  <= 1'b0;
      taken_q <= 1'b0;
      pc_q    <= '0;
      en_q    <= 1'b0;
      stall_q <= 1'b0;
      br_q    <= '0;
      mis_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (rdy) begin
      state_q <= state_d;
      jump_q  <= jump_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
      stall_q <= stall_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
      if (bus.rob_update_en) ctr_q[train_idx] <= train_ctr_next;
    end
  end

  assign bus.is_jump_instr       = jump_q;
  assign bus.predicted_jump      = taken_q;
  assign bus.predict_jump_pc     = pc_q;
  assign bus.predictor_enable_if = en_q;
  assign bus.predictor_stall_if  = stall_q;
  assign bus.perf_branches       = br_q;
  assign bus.perf_mispredicts    = mis_q;
  assign state_dbg               = (state_q == WAIT_JALR);

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed scenarios with literal pins, then random traffic
// compared every cycle against an arithmetic model of the predictor.
`ifndef OPLEN
`define OPLEN 6
`endif
`ifndef JALR
`define JALR 6'd9
`endif

module tb_bht_predictor;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic state_dbg;

  bht_predictor_if #(.PERF_W(16)) bus ();

  bht_predictor #(
    .IDX_BITS(8), .CTR_BITS(2), .CTR_INIT(1), .PERF_W(16)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int          ctr_m [256];
  bit          m_wait, m_jump, m_taken, m_en, m_stall;
  logic [31:0] m_pc;
  int          m_br, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int b_imm_of(input logic [31:0] w);
    return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
  endfunction

  function automatic int j_imm_of(input logic [31:0] w);
    return (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 +
           int'(w[30:21]) * 2;
  endfunction

  function automatic logic [31:0] enc_branch(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'd99};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'd111};
  endfunction

  function automatic logic [31:0] enc_jalr();
    return {12'd0, 5'd1, 3'b000, 5'd0, 7'd103};
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  // Expected outputs after the coming clock edge, from the current inputs.
  function automatic void model_step();
    int i;
    if (rst) begin
      m_wait = 0; m_jump = 0; m_taken = 0; m_en = 0; m_stall = 0;
      m_pc = 0; m_br = 0; m_mis = 0;
      foreach (ctr_m[k]) ctr_m[k] = 1;
      return;
    end
    if (!rdy) return;
    m_en = 0;
    if (bus.jump_wrong) begin
      m_stall = 0;
      m_wait  = 0;
    end else if (m_wait) begin
      if (bus.alu_broadcast && bus.alu_broadcast_op == `JALR) begin
        m_pc = bus.alu_jumping_pc; m_jump = 1; m_taken = 1;
        m_stall = 0; m_en = 1; m_wait = 0;
      end
    end else if (bus.if_success) begin
      case (bus.if_instr[6:0])
        7'd111: begin
          m_jump = 1; m_taken = 1; m_en = 1;
          m_pc = bus.if_pc + 32'(j_imm_of(bus.if_instr));
        end
        7'd103: begin
          m_jump = 1; m_taken = 1; m_stall = 1; m_wait = 1;
        end
        7'd99: begin
          m_jump = 1; m_en = 1;
          m_taken = (ctr_m[idx_of(bus.if_pc)] >= 2);
          m_pc = m_taken ? bus.if_pc + 32'(b_imm_of(bus.if_instr)) : bus.if_pc + 32'd4;
        end
        default: begin
          m_jump = 0; m_taken = 0; m_en = 1;
          m_pc = bus.if_pc + 32'd4;
        end
      endcase
    end
    if (bus.rob_update_en) begin
      i = idx_of(bus.rob_update_pc);
      if (bus.rob_real_jump) ctr_m[i] = (ctr_m[i] < 3) ? ctr_m[i] + 1 : 3;
      else                   ctr_m[i] = (ctr_m[i] > 0) ? ctr_m[i] - 1 : 0;
      if (m_br < 65535) m_br++;
    end
    if (bus.jump_wrong && m_mis < 65535) m_mis++;
  endfunction

  task automatic compare_all();
    check("is_jump", 32'(bus.is_jump_instr), 32'(m_jump));
    check("taken", 32'(bus.predicted_jump), 32'(m_taken));
    check("pc", bus.predict_jump_pc, m_pc);
    check("enable_if", 32'(bus.predictor_enable_if), 32'(m_en));
    check("stall_if", 32'(bus.predictor_stall_if), 32'(m_stall));
    check("perf_branches", 32'(bus.perf_branches), 32'(m_br));
    check("perf_mispredicts", 32'(bus.perf_mispredicts), 32'(m_mis));
    check("state_waiting", 32'(state_dbg), 32'(m_wait));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.if_success = 0; bus.if_pc = 0; bus.if_instr = 0;
    bus.alu_broadcast = 0; bus.alu_broadcast_op = 0; bus.alu_jumping_pc = 0;
    bus.rob_update_en = 0; bus.rob_update_pc = 0; bus.rob_real_jump = 0;
    bus.jump_wrong = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); cycle();
    rst = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_success = 1; bus.if_pc = pc; bus.if_instr = instr;
    cycle();
    clear_inputs();
  endtask

  task automatic train(input logic [31:0] pc, input logic real_jump);
    bus.rob_update_en = 1; bus.rob_update_pc = pc; bus.rob_real_jump = real_jump;
    cycle();
    clear_inputs();
  endtask

  initial begin
    rdy = 1;
    do_reset();
    check("pin_reset_pc", bus.predict_jump_pc, 32'h0);
    check("pin_reset_en", 32'(bus.predictor_enable_if), 32'h0);

    // Branch at 0x100, counter at init -> not taken
    fetch(32'h100, enc_branch(16));
    check("pin_br_en", 32'(bus.predictor_enable_if), 32'h1);
    check("pin_br_taken", 32'(bus.predicted_jump), 32'h0);
    check("pin_br_pc", bus.predict_jump_pc, 32'h104);
    cycle();
    check("pin_en_pulse", 32'(bus.predictor_enable_if), 32'h0);

    train(32'h100, 1);
    train(32'h100, 1);
    fetch(32'h100, enc_branch(16));
    check("pin_trained_taken", 32'(bus.predicted_jump), 32'h1);
    check("pin_trained_pc", bus.predict_jump_pc, 32'h110);
    for (int k = 0; k < 4; k++) begin
      train(32'h100, 1);
      fetch(32'h100, enc_branch(16));
      check("pin_saturate_taken", 32'(bus.predicted_jump), 32'h1);
    end

    // Same-cycle lookup and update of a counter at 1
    bus.if_success = 1; bus.if_pc = 32'h180; bus.if_instr = enc_branch(16);
    bus.rob_update_en = 1; bus.rob_update_pc = 32'h180; bus.rob_real_jump = 1;
    cycle();
    clear_inputs();
    check("pin_same_cycle_taken", 32'(bus.predicted_jump), 32'h0);
    check("pin_same_cycle_pc", bus.predict_jump_pc, 32'h184);
    fetch(32'h180, enc_branch(16));
    check("pin_after_same_taken", 32'(bus.predicted_jump), 32'h1);

    // rdy=0 blocks training
    rdy = 0;
    bus.rob_update_en = 1; bus.rob_update_pc = 32'h1C0; bus.rob_real_jump = 1;
    cycle();
    bus.rob_update_en = 1;
    cycle();
    clear_inputs();
    rdy = 1;
    fetch(32'h1C0, enc_branch(16));
    check("pin_rdy_hold_taken", 32'(bus.predicted_jump), 32'h0);

    fetch(32'h200, enc_jal(-8));
    check("pin_jal_taken", 32'(bus.predicted_jump), 32'h1);
    check("pin_jal_pc", bus.predict_jump_pc, 32'h1F8);
    check("pin_jal_en", 32'(bus.predictor_enable_if), 32'h1);

    fetch(32'h240, enc_jalr());
    check("pin_jalr_stall", 32'(bus.predictor_stall_if), 32'h1);
    check("pin_jalr_en", 32'(bus.predictor_enable_if), 32'h0);
    fetch(32'h300, enc_jal(64));
    check("pin_ignored_stall", 32'(bus.predictor_stall_if), 32'h1);
    check("pin_ignored_en", 32'(bus.predictor_enable_if), 32'h0);
    bus.alu_broadcast = 1; bus.alu_broadcast_op = 6'd3; bus.alu_jumping_pc = 32'h5000;
    cycle();
    check("pin_wrong_op_stall", 32'(bus.predictor_stall_if), 32'h1);
    bus.alu_broadcast_op = `JALR; bus.alu_jumping_pc = 32'h3000;
    cycle();
    clear_inputs();
    check("pin_resolve_pc", bus.predict_jump_pc, 32'h3000);
    check("pin_resolve_stall", 32'(bus.predictor_stall_if), 32'h0);
    check("pin_resolve_en", 32'(bus.predictor_enable_if), 32'h1);
    cycle();
    check("pin_resolve_pulse", 32'(bus.predictor_enable_if), 32'h0);

    // Flush while a JALR is pending, with a same-cycle commit
    do_reset();
    fetch(32'h280, enc_jalr());
    bus.jump_wrong = 1;
    bus.rob_update_en = 1; bus.rob_update_pc = 32'h2C0; bus.rob_real_jump = 1;
    bus.alu_broadcast = 1; bus.alu_broadcast_op = `JALR; bus.alu_jumping_pc = 32'h4000;
    cycle();
    clear_inputs();
    check("pin_flush_stall", 32'(bus.predictor_stall_if), 32'h0);
    check("pin_flush_en", 32'(bus.predictor_enable_if), 32'h0);
    check("pin_flush_state", 32'(state_dbg), 32'h0);
    check("pin_flush_mis", 32'(bus.perf_mispredicts), 32'h1);
    check("pin_flush_br", 32'(bus.perf_branches), 32'h1);
    fetch(32'h2C0, enc_branch(16));
    check("pin_flush_trained", bus.predict_jump_pc, 32'h2D0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      int kind;
      r = $urandom();
      clear_inputs();
      rst = ($urandom_range(0, 999) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      bus.if_success = ($urandom_range(0, 2) != 0);
      bus.if_pc = (32'($urandom_range(0, 511)) << 2) | (32'($urandom_range(0, 3)) << 20);
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: bus.if_instr = enc_branch(int'($urandom_range(0, 4095)) * 2 - 4096);
        2: bus.if_instr = enc_jal(int'($urandom_range(0, 65535)) * 2 - 65536);
        3: bus.if_instr = enc_jalr();
        default: bus.if_instr = {r[31:7], ($urandom_range(0, 1) != 0) ? 7'h13 : 7'h33};
      endcase
      bus.alu_broadcast = ($urandom_range(0, 3) == 0);
      bus.alu_broadcast_op = ($urandom_range(0, 1) != 0) ? `JALR : `OPLEN'($urandom_range(0, 63));
      bus.alu_jumping_pc = $urandom();
      bus.rob_update_en = ($urandom_range(0, 2) == 0);
      bus.rob_update_pc = (32'($urandom_range(0, 511)) << 2) | (32'($urandom_range(0, 3)) << 24);
      bus.rob_real_jump = ($urandom_range(0, 2) != 0);
      bus.jump_wrong = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 0; rdy = 1;
    clear_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
